// File: rtl/booth_seq_mul.sv
// booth_seq_mul: iterative Booth multiplier, one add/sub + arithmetic-shift step per clock.
//
// Operands are extended by one bit (sign or zero, per is_signed), so the same Booth
// datapath handles signed and unsigned products.
//
// Build option: define BOOTH_RADIX4_EN for the radix-4 datapath. It retires two
// multiplier bits per cycle and gives the same results. Ports are identical in both builds.
//
// Ports:
//   clk, rst_n            clock (rising edge), async active-low reset
//   in_valid / in_ready   operand handshake; a, b, is_signed are sampled on acceptance
//   a, b     [WIDTH]      multiplicand / multiplier
//   out_valid / out_ready product handshake; p is held until it is consumed
//   p        [2*WIDTH]    product (two's complement or unsigned magnitude)
//   busy                  high while iterating
module booth_seq_mul #(
  parameter int WIDTH = 8
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               in_valid,
  output logic               in_ready,
  input  logic [WIDTH-1:0]   a,
  input  logic [WIDTH-1:0]   b,
  input  logic               is_signed,
  output logic               out_valid,
  input  logic               out_ready,
  output logic [2*WIDTH-1:0] p,
  output logic               busy
);

  localparam int CNT_W = $clog2(WIDTH + 2);
  localparam int N     = WIDTH + 1;
`ifdef BOOTH_RADIX4_EN
  localparam int NI    = N + (N % 2);   // even width so bits pair up
  localparam int STEPS = NI / 2;
`else
  localparam int NI    = N;
  localparam int STEPS = N;
`endif

  typedef enum logic [1:0] {IDLE, RUN, DONE} state_e;

  typedef struct packed {
    logic [WIDTH-1:0] a;
    logic [WIDTH-1:0] b;
    logic             is_signed;
  } req_t;

  req_t req;
  assign req = '{a: a, b: b, is_signed: is_signed};

  state_e             state_q, state_d;
  logic [NI-1:0]      acc_q, acc_d;
  logic [NI-1:0]      q_q, q_d;
  logic               q1_q, q1_d;
  logic [NI-1:0]      m_q, m_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic [2*WIDTH-1:0] p_q, p_d;

  logic [NI-1:0]      ext_a, ext_b;
  logic [NI-1:0]      acc_nx, q_nx;
  logic               q1_nx;
  logic [2*NI-1:0]    aq_nx;

  assign ext_a = {{(NI-WIDTH){req.is_signed & req.a[WIDTH-1]}}, req.a};
  assign ext_b = {{(NI-WIDTH){req.is_signed & req.b[WIDTH-1]}}, req.b};

  // One Booth step: add/sub, then arithmetic shift of {A,Q,q_1}.
`ifdef BOOTH_RADIX4_EN
  logic [NI:0] m_ext, pp, sum;
  always_comb begin
    m_ext = {m_q[NI-1], m_q};
    case ({q_q[1:0], q1_q})
      3'b001, 3'b010: pp = m_ext;
      3'b011:         pp = {m_q, 1'b0};
      3'b100:         pp = -{m_q, 1'b0};
      3'b101, 3'b110: pp = -m_ext;
      default:        pp = '0;
    endcase
    // One guard bit keeps A +/- 2M from overflowing before the shift by 2.
    sum    = {acc_q[NI-1], acc_q} + pp;
    acc_nx = {sum[NI], sum[NI:2]};
    q_nx   = {sum[1:0], q_q[NI-1:2]};
    q1_nx  = q_q[1];
  end
`else
  logic [NI-1:0] sum;
  always_comb begin
    case ({q_q[0], q1_q})
      2'b01:   sum = acc_q + m_q;
      2'b10:   sum = acc_q - m_q;
      default: sum = acc_q;
    endcase
    acc_nx = {sum[NI-1], sum[NI-1:1]};
    q_nx   = {sum[0], q_q[NI-1:1]};
    q1_nx  = q_q[0];
  end
`endif

  assign aq_nx = {acc_nx, q_nx};

  always_comb begin
    state_d = state_q;
    acc_d   = acc_q;
    q_d     = q_q;
    q1_d    = q1_q;
    m_d     = m_q;
    cnt_d   = cnt_q;
    p_d     = p_q;
    case (state_q)
      IDLE: begin
        if (in_valid) begin
          acc_d   = '0;
          q_d     = ext_b;
          q1_d    = 1'b0;
          m_d     = ext_a;
          cnt_d   = CNT_W'(STEPS);
          state_d = RUN;
        end
      end
      RUN: begin
        acc_d = acc_nx;
        q_d   = q_nx;
        q1_d  = q1_nx;
        cnt_d = cnt_q - CNT_W'(1);
        if (cnt_q == CNT_W'(1)) begin
          // Product modulo 2^(2*WIDTH); the extension bits above it are discarded.
          p_d     = aq_nx[2*WIDTH-1:0];
          state_d = DONE;
        end
      end
      DONE: begin
        if (out_ready) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      acc_q   <= '0;
      q_q     <= '0;
      q1_q    <= 1'b0;
      m_q     <= '0;
      cnt_q   <= '0;
      p_q     <= '0;
    end else begin
      state_q <= state_d;
      acc_q   <= acc_d;
      q_q     <= q_d;
      q1_q    <= q1_d;
      m_q     <= m_d;
      cnt_q   <= cnt_d;
      p_q     <= p_d;
    end
  end

  assign in_ready  = (state_q == IDLE);
  assign out_valid = (state_q == DONE);
  assign busy      = (state_q == RUN);
  assign p         = p_q;

endmodule

// File: doc/booth_seq_mul.md
Name: booth_seq_mul

Overview:
- Parametrised, iterative radix-2 Booth multiplier.
- Operand width is set by a parameter. Each operation selects signed or unsigned mode.
- Uses a valid/ready handshake on input and output, so it can be shared by datapath blocks that cannot afford a fully unrolled array.
- Computes one add/sub-and-arithmetic-shift step per clock, reusing a single adder/subtractor.

Parameters:
- WIDTH, 8, operand width in bits; legal range 4..32.
- CNT_W, $clog2(WIDTH+2), iteration counter width; derived, not overridden.

Ports:
- clk  in  1  single clock, rising edge.
- rst_n  in  1  asynchronous, active-low reset.
- in_valid  in  1  operands present.
- in_ready  out  1  block can accept operands.
- a  in  WIDTH  multiplicand (M).
- b  in  WIDTH  multiplier (Q).
- is_signed  in  1  1 = two's-complement operands, 0 = unsigned; sampled with a and b.
- out_valid  out  1  product available.
- out_ready  in  1  consumer accepts product.
- p  out  2*WIDTH  product.
- busy  out  1  high in RUN.

Behaviour:
- Reset (async assert, sync deassert handled upstream) sets:
  - state=IDLE, in_ready=1, out_valid=0, busy=0, p=0.
  - All internal registers (A, Q, q_1, M, count) = 0.
- Internal width N=WIDTH+1. Operands are extended to N bits: sign-extended if is_signed=1, zero-extended otherwise. This makes unsigned inputs valid Booth operands.
- States: IDLE, RUN, DONE.
- IDLE:
  - in_ready=1.
  - On in_valid&&in_ready, load A=0, Q=ext(b), q_1=0, M=ext(a), count=N; go to RUN.
- RUN:
  - in_ready=0, busy=1.
  - Each cycle, inspect {Q[0],q_1}:
    - 01 → A=A+M
    - 10 → A=A−M
    - 00 or 11 → A unchanged.
  - Then arithmetic-shift {A,Q,q_1} right one bit; A's MSB is replicated.
  - Decrement count. When count reaches 1 at the edge, go to DONE and latch p = low 2*WIDTH bits of {A,Q} after the final shift.
- Arithmetic rules:
  - Add/sub is N bits wide; overflow wraps modulo 2^N. N-bit extension guarantees a correct result.
  - Two's-complement result for signed mode; unsigned magnitude for unsigned mode.
- Latency:
  - out_valid rises exactly N rising edges after the accepting edge: 9 for WIDTH=8.
  - Minimum initiation interval is N+2 cycles.
- DONE:
  - out_valid=1. p is held stable until out_valid&&out_ready.
  - On that edge: out_valid=0, go to IDLE. p keeps its last value.
- in_valid while not IDLE is ignored; operands are not captured.
- a, b and is_signed may change freely after acceptance; the operation uses only the captured values.
- out_ready while out_valid=0 has no effect.
- Reset mid-RUN or mid-DONE: immediate return to reset values. The in-flight result is discarded and no out_valid pulse is emitted.
- Boundary operands (signed WIDTH=8):
  - −128×−128 = +16384 with no overflow.
  - Zero operands complete in the same N cycles; there is no early termination.

Optional Feature:
- Macro BOOTH_RADIX4_EN.
- Defined:
  - Operands are extended to N4 = N rounded up to even (10 for WIDTH=8).
  - Each RUN cycle decodes {Q[1],Q[0],q_1} into a partial product from {0, ±M, ±2M}, adds it on an N4+1-bit adder, and shifts arithmetically by 2.
  - count starts at N4/2, giving latency N4/2 edges (5 for WIDTH=8).
  - Results are identical to radix-2.
- Undefined: radix-2 as above. Ports are identical in both builds.

Test Plan:
- Signed, WIDTH=8, a=8'h80 (−128), b=8'h80 → p=16'h4000, out_valid exactly 9 edges after accept (5 with BOOTH_RADIX4_EN).
- Signed a=8'h7F, b=8'h80 → p=16'hC080 (−16256). Signed a=8'hFF, b=8'h01 → p=16'hFFFF.
- Unsigned a=8'hFF, b=8'hFF → p=16'hFE01. Same operands with is_signed=1 → p=16'h0001.
- Backpressure: hold out_ready=0 for 5 cycles after out_valid → p and out_valid stable, in_ready=0, a new in_valid is ignored. Then out_ready=1 → IDLE next cycle, and the next operation's result is correct.
- Reset mid-op: assert rst_n=0 at iteration 4 → all outputs at reset values immediately. Release and run 3×−5 → p=16'hFFF1 with no stale out_valid.
- Random sweep: 10k random a, b, is_signed (WIDTH=8 and WIDTH=16, with in_valid/out_ready jitter) → p matches reference model product modulo 2^(2*WIDTH).
